// File: rtl/uart_dpram_ctrl_pkg.sv
// uart_dpram_ctrl shared types.
// State encoding and buffer depth helpers.
package uart_dpram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    RD_WAIT   = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/uart_dpram_ctrl.sv
// UART -> dual-port RAM -> UART sequencer.
// Buffers received bytes, replays them on a key press.
module uart_dpram_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              key_flag,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              send_en,
  input  logic              tx_done,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overrun
);

  import uart_dpram_ctrl_pkg::*;

  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam cnt_t DEPTH_C = cnt_t'(depth_of(ADDR_W));

  state_t state;
  addr_t  rptr;
  logic   fwd;

  logic wr_ok;
  logic key_ok;
  logic last;
  cnt_t cnt_nx;

  assign wr_ok  = (state == IDLE) && rx_done
               && (count != DEPTH_C);
  assign cnt_nx = count + cnt_t'(wr_ok);
  assign key_ok = key_flag && (cnt_nx != '0);
  assign last   = {1'b0, rptr} == (count - cnt_t'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rptr      <= '0;
      fwd       <= 1'b0;
      ram_wren  <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_raddr <= '0;
      tx_data   <= '0;
      send_en   <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ram_wren <= 1'b0;
      send_en  <= 1'b0;
      if (rx_done && !wr_ok)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (wr_ok) begin
            ram_wren  <= 1'b1;
            ram_waddr <= count[ADDR_W-1:0];
            ram_wdata <= rx_data;
            count     <= cnt_nx;
          end
          if (key_ok) begin
            state     <= RD_ADDR;
            rptr      <= '0;
            ram_raddr <= '0;
            busy      <= 1'b1;
            // byte 0 written this cycle: RAM read would race it
            fwd       <= wr_ok && (count == '0);
          end
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          tx_data <= fwd ? ram_wdata : ram_rdata;
          send_en <= 1'b1;
          fwd     <= 1'b0;
          state   <= SEND;
        end
        SEND: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (tx_done) begin
            if (last) begin
              count <= '0;
              rptr  <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              rptr      <= rptr + addr_t'(1);
              ram_raddr <= rptr + addr_t'(1);
              state     <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
